// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Merges ALU and load (MEM) results into a single register-file write port and
// tracks outstanding destination registers for decode hazard checks.
//
// ALU results are held in a 2-entry FIFO. Load results are never buffered; MEM
// wins arbitration unless a full ALU FIFO has waited STARVE_LIMIT consecutive
// cycles. In that case the FIFO head is forced through and MEM is stalled for
// one cycle. The selected entry is written one cycle after selection.
//
// Ports
//   CLK, reset            clock, synchronous active-high reset
//   alu_valid/dr/data     ALU result offer (valid/ready handshake)
//   alu_ready             ALU FIFO not full
//   mem_valid/dr/data     load result offer
//   mem_ready             load result accepted this cycle
//   DR, WB_DATA, ST_REG   registered register-file write port
//   iss_valid, iss_dr     issued instruction marks iss_dr pending
//   SR1, SR2              decode source indices
//   busy_one, busy_two    source register has an outstanding write
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dr,
    input  logic [63:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_dr,
    input  logic [63:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  DR,
    output logic [63:0] WB_DATA,
    output logic        ST_REG,
    input  logic        iss_valid,
    input  logic [4:0]  iss_dr,
    input  logic [4:0]  SR1,
    input  logic [4:0]  SR2,
    output logic        busy_one,
    output logic        busy_two
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [4:0]  r_fifo_dr   [2];
    logic [63:0] r_fifo_data [2];
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic [3:0]  r_starve;
    logic [31:0] r_pending;
    logic [4:0]  r_dr;
    logic [63:0] r_data;
    logic        r_st;

    logic        w_full;
    logic        w_empty;
    logic        w_force;
    logic        w_mem_sel;
    logic        w_fifo_sel;
    logic        w_sel_valid;
    logic        w_push;
    logic        w_wr_ptr;
    logic [4:0]  w_sel_dr;
    logic [63:0] w_sel_data;
    logic [1:0]  w_count_next;
    logic [3:0]  w_starve_next;
    logic [31:0] w_clr_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_pending_next;

    assign w_full      = (r_count == 2'd2);
    assign w_empty     = (r_count == 2'd0);
    assign w_force     = w_full && (r_starve == LP_LIMIT);
    assign w_mem_sel   = mem_valid && !w_force;
    assign w_fifo_sel  = !w_mem_sel && !w_empty;
    assign w_sel_valid = w_mem_sel || w_fifo_sel;
    // A push is only possible when not full, so it never races a full-FIFO pop.
    assign w_push      = alu_valid && !w_full;
    // With 0 or 2 entries the write slot coincides with the read slot.
    assign w_wr_ptr    = r_rd_ptr ^ r_count[0];

    assign alu_ready = !w_full;
    assign mem_ready = w_mem_sel;
    assign DR        = r_dr;
    assign WB_DATA   = r_data;
    assign ST_REG    = r_st;

    // Bit 0 of the scoreboard is never set, so x0 always reads not busy.
    assign busy_one = (SR1 != 5'd0) && r_pending[SR1];
    assign busy_two = (SR2 != 5'd0) && r_pending[SR2];

    // Write-port source mux
    always_comb begin
        w_sel_dr   = 5'd0;
        w_sel_data = 64'd0;
        if (w_mem_sel) begin
            w_sel_dr   = mem_dr;
            w_sel_data = mem_data;
        end else begin
            w_sel_dr   = r_fifo_dr[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end
    end

    // FIFO occupancy update
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_fifo_sel})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Starvation counter: only counts while full and losing to MEM
    always_comb begin
        w_starve_next = r_starve;
        if (w_fifo_sel || !w_full) begin
            w_starve_next = 4'd0;
        end else if (w_mem_sel && (r_starve != LP_LIMIT)) begin
            w_starve_next = r_starve + 4'd1;
        end else begin
            w_starve_next = r_starve;
        end
    end

    // Scoreboard: set wins over clear on the same index
    always_comb begin
        w_clr_mask     = r_st ? (32'd1 << r_dr) : 32'd0;
        w_set_mask     = (iss_valid && (iss_dr != 5'd0)) ? (32'd1 << iss_dr) : 32'd0;
        w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end

    // FIFO data slots (contents are don't-care while invalid)
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_dr[w_wr_ptr]   <= alu_dr;
            r_fifo_data[w_wr_ptr] <= alu_data;
        end
    end

    // Control state, scoreboard and registered write port
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_starve  <= 4'd0;
            r_pending <= 32'd0;
            r_dr      <= 5'd0;
            r_data    <= 64'd0;
            r_st      <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_starve  <= w_starve_next;
            r_pending <= w_pending_next;
            if (w_fifo_sel) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_sel_valid) begin
                r_dr   <= w_sel_dr;
                r_data <= w_sel_data;
                r_st   <= (w_sel_dr != 5'd0);
            end else begin
                r_st   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for writeback_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int LIMIT = 4;

    logic        CLK;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_dr;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_dr;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic [4:0]  DR;
    logic [63:0] WB_DATA;
    logic        ST_REG;
    logic        iss_valid;
    logic [4:0]  iss_dr;
    logic [4:0]  SR1;
    logic [4:0]  SR2;
    logic        busy_one;
    logic        busy_two;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .reset(reset),
        .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_ready(mem_ready),
        .DR(DR), .WB_DATA(WB_DATA), .ST_REG(ST_REG),
        .iss_valid(iss_valid), .iss_dr(iss_dr), .SR1(SR1), .SR2(SR2),
        .busy_one(busy_one), .busy_two(busy_two)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  dr;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    bit [31:0]   m_pend;
    bit          m_st;
    logic [4:0]  m_dr;
    logic [63:0] m_data;
    bit          e_alu_ready, e_mem_ready, e_busy1, e_busy2;

    task automatic model_comb();
        bit full;
        full        = (mq.size() == 2);
        e_alu_ready = !full;
        e_mem_ready = mem_valid && !(full && (m_starve == LIMIT));
        e_busy1     = (SR1 != 5'd0) && m_pend[SR1];
        e_busy2     = (SR2 != 5'd0) && m_pend[SR2];
    endtask

    task automatic model_seq();
        bit   full, sel, popped;
        ent_t s;
        if (reset) begin
            mq.delete();
            m_starve = 0;
            m_pend   = '0;
            m_st     = 1'b0;
            m_dr     = 5'd0;
            m_data   = 64'd0;
        end else begin
            full = (mq.size() == 2);
            model_comb();
            sel = 1'b0; popped = 1'b0; s = '0;
            if (e_mem_ready) begin
                sel = 1'b1; s = '{dr: mem_dr, data: mem_data};
            end else if (mq.size() > 0) begin
                sel = 1'b1; s = mq.pop_front(); popped = 1'b1;
            end
            if (alu_valid && !full) mq.push_back('{dr: alu_dr, data: alu_data});
            if (popped || !full) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (m_st) m_pend[m_dr] = 1'b0;
            if (iss_valid && iss_dr != 5'd0) m_pend[iss_dr] = 1'b1;
            if (sel) begin
                m_st = (s.dr != 5'd0); m_dr = s.dr; m_data = s.data;
            end else begin
                m_st = 1'b0;
            end
        end
    endtask

    // Inputs change 1 time unit after the edge; combinational outputs are
    // sampled 3 units after the edge, registered outputs 1 unit after.
    task automatic settle();
        #2;
        model_comb();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_seq();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; alu_valid = 1'b0; alu_dr = 5'd0; alu_data = 64'd0;
        mem_valid = 1'b0; mem_dr = 5'd0; mem_data = 64'd0;
        iss_valid = 1'b0; iss_dr = 5'd0; SR1 = 5'd0; SR2 = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; mem_dr = 5'd4;
        tick();
        n_checks++;
        if ({ST_REG, DR, WB_DATA} !== {1'b0, 5'd0, 64'd0})
            $display("FAIL reset_outputs got st=%b dr=%0d data=%h exp 0/0/0", ST_REG, DR, WB_DATA);
        else n_pass++;
        idle_inputs();
        mem_valid = 1'b1; mem_dr = 5'd0; SR1 = 5'd1; SR2 = 5'd31;
        settle();
        n_checks++;
        if ({alu_ready, mem_ready, busy_one, busy_two} !== 4'b1100)
            $display("FAIL reset_comb got ar=%b mr=%b b1=%b b2=%b exp 1100", alu_ready, mem_ready, busy_one, busy_two);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_only();
        logic [4:0]  drs [3] = '{5'd5, 5'd6, 5'd0};
        logic [63:0] dts [3] = '{64'hA, 64'hB, 64'h0};
        bit          vld [3] = '{1'b1, 1'b1, 1'b0};
        bit          est [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                alu_valid = vld[c]; alu_dr = drs[c]; alu_data = dts[c];
            end else begin
                alu_valid = 1'b0;
            end
            settle();
            n_checks++;
            if (alu_ready !== 1'b1) $display("FAIL alu_only_ready cyc %0d got %b exp 1", c, alu_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (ST_REG !== est[c]) $display("FAIL alu_only_st cyc %0d got %b exp %b", c, ST_REG, est[c]);
            else n_pass++;
            if (est[c]) begin
                n_checks++;
                if ({DR, WB_DATA} !== {drs[c-1], dts[c-1]})
                    $display("FAIL alu_only_data cyc %0d got %0d/%h exp %0d/%h", c, DR, WB_DATA, drs[c-1], dts[c-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        idle_inputs();
        mem_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            mem_dr = 5'(10 + c); mem_data = 64'(c * 16);
            alu_valid = (c <= 2);
            alu_dr = 5'(c); alu_data = 64'(c * 32'h111);
            settle();
            if (c >= 3 && c <= 7) begin
                n_checks++;
                if ({mem_ready, alu_ready} !== {(c != 7), 1'b0})
                    $display("FAIL contention_ready cyc %0d got mr=%b ar=%b exp mr=%b ar=0", c, mem_ready, alu_ready, c != 7);
                else n_pass++;
            end
            tick();
            n_checks++;
            if (c == 7) begin
                if ({ST_REG, DR, WB_DATA} !== {1'b1, 5'd1, 64'h111})
                    $display("FAIL contention_forced got st=%b dr=%0d data=%h exp 1/1/111", ST_REG, DR, WB_DATA);
                else n_pass++;
            end else begin
                if ({ST_REG, DR} !== {1'b1, 5'(10 + c)})
                    $display("FAIL contention_mem cyc %0d got st=%b dr=%0d exp 1/%0d", c, ST_REG, DR, 10 + c);
                else n_pass++;
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if ({ST_REG, DR, WB_DATA} !== {1'b1, 5'd2, 64'h222})
            $display("FAIL contention_drain got st=%b dr=%0d data=%h exp 1/2/222", ST_REG, DR, WB_DATA);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0_write();
        idle_inputs();
        iss_valid = 1'b1; iss_dr = 5'd9;
        tick();
        idle_inputs();
        SR1 = 5'd9; SR2 = 5'd0;
        for (int c = 0; c < 4; c++) begin
            alu_valid = (c == 0); alu_dr = 5'd0; alu_data = 64'hFFFF;
            settle();
            n_checks++;
            if ({busy_one, busy_two, alu_ready} !== 3'b101)
                $display("FAIL x0_busy cyc %0d got b1=%b b2=%b ar=%b exp 101", c, busy_one, busy_two, alu_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (ST_REG !== 1'b0) $display("FAIL x0_st cyc %0d got %b exp 0", c, ST_REG);
            else n_pass++;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_dr = 5'd9; mem_data = 64'h99;
        tick();
        mem_valid = 1'b0;
        tick();
        tick();
        settle();
        n_checks++;
        if (busy_one !== 1'b0) $display("FAIL x0_cleanup got %b exp 0", busy_one);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        SR1 = 5'd7;
        for (int pass = 0; pass < 2; pass++) begin
            iss_valid = 1'b1; iss_dr = 5'd7;
            tick();
            iss_valid = 1'b0;
            mem_valid = 1'b1; mem_dr = 5'd7; mem_data = 64'h77;
            settle();
            n_checks++;
            if (busy_one !== 1'b1) $display("FAIL sb_set pass %0d got %b exp 1", pass, busy_one);
            else n_pass++;
            tick();
            n_checks++;
            if ({ST_REG, DR} !== {1'b1, 5'd7}) $display("FAIL sb_write pass %0d got st=%b dr=%0d exp 1/7", pass, ST_REG, DR);
            else n_pass++;
            mem_valid = 1'b0;
            iss_valid = (pass == 1);
            settle();
            n_checks++;
            if (busy_one !== 1'b1) $display("FAIL sb_before_clear pass %0d got %b exp 1", pass, busy_one);
            else n_pass++;
            tick();
            iss_valid = 1'b0;
            settle();
            n_checks++;
            if (busy_one !== (pass == 1)) $display("FAIL sb_after_clear pass %0d got %b exp %b", pass, busy_one, pass == 1);
            else n_pass++;
        end
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        mem_valid = 1'b1; mem_dr = 5'd20;
        alu_valid = 1'b1; alu_dr = 5'd11; alu_data = 64'h11; iss_valid = 1'b1; iss_dr = 5'd3;
        tick();
        alu_dr = 5'd12; alu_data = 64'h12; iss_valid = 1'b0; SR1 = 5'd3;
        tick();
        settle();
        n_checks++;
        if ({alu_ready, busy_one} !== 2'b01) $display("FAIL rst_mid_pre got ar=%b b1=%b exp 01", alu_ready, busy_one);
        else n_pass++;
        reset = 1'b1; iss_valid = 1'b1; iss_dr = 5'd3;
        tick();
        idle_inputs();
        SR1 = 5'd3;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if ({alu_ready, mem_ready, busy_one} !== 3'b100)
                $display("FAIL rst_mid_comb cyc %0d got ar=%b mr=%b b1=%b exp 100", c, alu_ready, mem_ready, busy_one);
            else n_pass++;
            tick();
            n_checks++;
            if (ST_REG !== 1'b0) $display("FAIL rst_mid_st cyc %0d got %b exp 0", c, ST_REG);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_dr    = 5'($urandom_range(0, 31));
            alu_data  = {32'($urandom), 32'($urandom)};
            mem_valid = ($urandom_range(0, 9) < 7);
            mem_dr    = 5'($urandom_range(0, 31));
            mem_data  = {32'($urandom), 32'($urandom)};
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_dr    = 5'($urandom_range(0, 31));
            SR1       = 5'($urandom_range(0, 31));
            SR2       = 5'($urandom_range(0, 31));
            settle();
            n_checks++;
            if ({alu_ready, mem_ready, busy_one, busy_two} !== {e_alu_ready, e_mem_ready, e_busy1, e_busy2})
                $display("FAIL rnd_comb cyc %0d got %b%b%b%b exp %b%b%b%b", c,
                         alu_ready, mem_ready, busy_one, busy_two, e_alu_ready, e_mem_ready, e_busy1, e_busy2);
            else n_pass++;
            tick();
            n_checks++;
            if (ST_REG !== m_st) $display("FAIL rnd_st cyc %0d got %b exp %b", c, ST_REG, m_st);
            else n_pass++;
            if (m_st) begin
                n_checks++;
                if ({DR, WB_DATA} !== {m_dr, m_data})
                    $display("FAIL rnd_data cyc %0d got %0d/%h exp %0d/%h", c, DR, WB_DATA, m_dr, m_data);
                else n_pass++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_only();
        test_contention();
        test_x0_write();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive cycles a full ALU buffer may wait on MEM before ALU is forced a grant (legal range 1-15).
REQ-002 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: alu_valid  input  1  ALU result offered.
REQ-005 Port: alu_dr  input  5  ALU destination register.
REQ-006 Port: alu_data  input  64  ALU result.
REQ-007 Port: alu_ready  output  1  ALU buffer can accept; transfer when alu_valid and alu_ready.
REQ-008 Port: mem_valid  input  1  load result offered.
REQ-009 Port: mem_dr  input  5  load destination register.
REQ-010 Port: mem_data  input  64  load result.
REQ-011 Port: mem_ready  output  1  load result accepted this cycle.
REQ-012 Port: DR  output  5  register-file write index.
REQ-013 Port: WB_DATA  output  64  register-file write data.
REQ-014 Port: ST_REG  output  1  register-file write enable.
REQ-015 Port: iss_valid  input  1  instruction issued that will write iss_dr.
REQ-016 Port: iss_dr  input  5  destination of issued instruction.
REQ-017 Port: SR1, SR2  input  5 each  decode source indices.
REQ-018 Port: busy_one, busy_two  output  1 each  source has an outstanding write.

Function
REQ-019 ALU results SHALL enter a 2-entry FIFO; alu_ready = FIFO not full (combinational from state only).
REQ-020 MEM results SHALL bypass buffering; mem_ready = mem_valid and no ALU forced grant this cycle.
REQ-021 Each cycle at most one source SHALL be selected: MEM if mem_ready, else FIFO head if FIFO non-empty, else none.
REQ-022 Starve counter SHALL increment each cycle FIFO is full and MEM is selected, clear on any FIFO pop or when FIFO not full, saturate at STARVE_LIMIT.
REQ-023 When starve counter equals STARVE_LIMIT and FIFO is full, FIFO head SHALL be selected and mem_ready SHALL be 0 for that cycle.
REQ-024 Selected entry SHALL appear on DR/WB_DATA with ST_REG=1 exactly one cycle after selection (registered outputs); with no selection ST_REG=0 and DR/WB_DATA hold.
REQ-025 Selected entry with destination 0 SHALL be consumed (pop/handshake) but produce ST_REG=0.
REQ-026 FIFO push and pop in the same cycle SHALL be allowed when full-then-pop or empty-then-push ordering is preserved: order of ALU results SHALL never change; simultaneous push and pop on full FIFO is not allowed because alu_ready=0.
REQ-027 Scoreboard: 32 pending bits; iss_valid with iss_dr!=0 SHALL set pending[iss_dr] at the edge.
REQ-028 pending[DR] SHALL clear at the edge where ST_REG=1 is sampled (same edge the register file writes).
REQ-029 Same-edge set and clear of the same index SHALL leave the bit set.
REQ-030 busy_one = pending[SR1], busy_two = pending[SR2], combinational; index 0 SHALL always read not busy.

Reset
REQ-031 On reset sampled high: FIFO empty, starve counter 0, pending all 0, ST_REG=0, DR=0, WB_DATA=0; alu_ready=1 and mem_ready=mem_valid in the following cycle.
REQ-032 Reset SHALL override all same-cycle inputs; in-flight FIFO entries are discarded without a write.

Verification
REQ-033 ALU-only: push dr=5 data=0xA then dr=6 data=0xB on consecutive cycles, mem_valid=0 -> ST_REG pulses on two consecutive cycles with DR=5/0xA then DR=6/0xB, alu_ready stays 1.
REQ-034 Contention: FIFO full, mem_valid held 1 with STARVE_LIMIT=4 -> 4 MEM writes, then mem_ready=0 for one cycle and FIFO head written.
REQ-035 x0 write: ALU dr=0 data=0xFFFF -> consumed, ST_REG stays 0, pending unchanged.
REQ-036 Scoreboard: iss dr=7, SR1=7 -> busy_one=1; after MEM write dr=7 ST_REG cycle -> busy_one=0 next cycle; iss dr=7 on that same edge -> busy_one stays 1.
REQ-037 Reset mid-operation: FIFO holding 2 entries, pending[3]=1, reset for one cycle -> no ST_REG pulse afterwards, busy for SR1=3 is 0, alu_ready=1.
